// File: rtl/qspi_read_scheduler_pkg.sv
// rtl/qspi_read_scheduler_pkg.sv - shared state encoding and word-size constant
package qspi_read_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/qspi_rr_arbiter.sv
// rtl/qspi_rr_arbiter.sv - round-robin grant search with registered last-grant pointer
module qspi_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  input  logic [IDW-1:0]  update_id,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] probe;
  int             idx;

  // Pointer to the requester that most recently finished; reset makes requester 0 first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (update) begin
      last_grant <= update_id;
    end
  end

  // First set request bit searching upward from last_grant+1, wrapping modulo NREQ
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    probe       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_grant) + k) % NREQ;
      probe = IDW'(idx);
      if (!grant_valid && req[probe]) begin
        grant_valid = 1'b1;
        grant_idx   = probe;
      end
    end
  end

endmodule

// File: rtl/qspi_read_scheduler.sv
// rtl/qspi_read_scheduler.sv - round-robin, boundary-aligned chunking read scheduler
module qspi_read_scheduler
  import qspi_read_scheduler_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_CHUNK = 64,
  parameter int IDW       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [16*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_done,
  output logic                 req_aborted,
  output logic                 eng_start,
  output logic [31:0]          eng_addr,
  output logic [15:0]          eng_size,
  input  logic                 eng_done,
  input  logic [7:0]           fifo_space,
  input  logic                 abort,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int OFFW = $clog2(MAX_CHUNK);

  state_t         state;
  logic [31:0]    cur_addr;
  logic [16:0]    remaining;
  logic           abort_latch;
  logic           grant_valid;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    sel_addr;
  logic [15:0]    sel_len;
  logic [16:0]    room;
  logic [16:0]    chunk;
  logic           fifo_ok;
  logic           abort_now;

  qspi_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_valid),
    .update      (state == ST_FIN),
    .update_id   (grant_id),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Selected request fields, chunk size up to the next MAX_CHUNK boundary, FIFO room test
  always_comb begin
    sel_addr  = req_addr[32*grant_idx +: 32];
    sel_len   = req_len[16*grant_idx +: 16];
    room      = 17'(MAX_CHUNK) - {{(17-OFFW){1'b0}}, cur_addr[OFFW-1:0]};
    chunk     = (remaining < room) ? remaining : room;
    fifo_ok   = (17'(fifo_space) * 17'(WORD_BYTES)) >= chunk;
    abort_now = abort_latch | abort;
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      abort_latch <= 1'b0;
      req_ready   <= '0;
      req_done    <= '0;
      req_aborted <= 1'b0;
      eng_start   <= 1'b0;
      eng_addr    <= '0;
      eng_size    <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
    end else begin
      req_ready   <= '0;
      req_done    <= '0;
      req_aborted <= 1'b0;
      eng_start   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            req_ready[grant_idx] <= 1'b1;
            grant_id    <= grant_idx;
            cur_addr    <= sel_addr & ~32'(WORD_BYTES - 1);
            remaining   <= ({1'b0, sel_len} + 17'(WORD_BYTES - 1)) & ~17'(WORD_BYTES - 1);
            abort_latch <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) abort_latch <= 1'b1;
          // A zero-length request passes through here so its done pulse lands two cycles after ready
          if (abort_now || remaining == 17'd0) begin
            state <= ST_FIN;
          end else if (fifo_ok) begin
            eng_start <= 1'b1;
            eng_addr  <= cur_addr;
            eng_size  <= chunk[15:0];
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) abort_latch <= 1'b1;
          if (eng_done) begin
            cur_addr  <= cur_addr + {16'd0, eng_size};
            remaining <= remaining - {1'b0, eng_size};
            if (remaining == {1'b0, eng_size} || abort_now) state <= ST_FIN;
            else                                            state <= ST_ISSUE;
          end
        end
        ST_FIN: begin
          req_done[grant_id] <= 1'b1;
          req_aborted        <= abort_latch && (remaining != 17'd0);
          busy               <= 1'b0;
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
